// File: rtl/regfile_pkg.sv
// ============================================================================
// Package : regfile_pkg
// Shared widths and the late-result entry type for the register-file writer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Circular buffer of late write-back results with per-entry valid flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  wb_entry_t                           push_entry,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output logic [AW:0]                         count,
  output wb_entry_t                           head,
  output logic [DEPTH-1:0]                    valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_waddr
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  wb_entry_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  assign count = r_wr_ptr - r_rd_ptr;
  assign full  = (count == C_DEPTH);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= push_entry;
  end

  // An entry is live when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] w_offs;
      assign w_offs          = AW'(gi) - r_rd_ptr[AW-1:0];
      assign valid[gi]       = ({1'b0, w_offs} < count);
      assign entry_waddr[gi] = r_mem[gi].waddr;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_writeback_unit.sv
// ============================================================================
// Module : regfile_writeback_unit
// Merges pipeline and late results onto the single register-file write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_writeback_unit
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wr,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [XLEN-1:0]       pipe_wdata,
  output logic                  pipe_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_waddr,
  input  logic [XLEN-1:0]       lsu_wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  reg_wr,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic                              w_full;
  logic                              w_empty;
  logic [AW:0]                       w_count;
  wb_entry_t                         w_head;
  wb_entry_t                         w_push_entry;
  logic [DEPTH-1:0]                  w_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  w_entry_waddr;
  logic [NUM_REGS-1:0]               w_pend;
  logic                              w_push;
  logic                              w_pop;
  logic                              w_pipe_ok;
  logic                              w_load_pipe;

  // Writes to x0 are handshaken but never stored.
  assign lsu_ready    = reset && (w_count < C_DEPTH);
  assign w_push       = lsu_valid && lsu_ready && (lsu_waddr != '0);
  assign w_push_entry = '{waddr: lsu_waddr, wdata: lsu_wdata};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (w_push),
    .push_entry  (w_push_entry),
    .pop         (w_pop),
    .full        (w_full),
    .empty       (w_empty),
    .count       (w_count),
    .head        (w_head),
    .valid       (w_valid),
    .entry_waddr (w_entry_waddr)
  );

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) w_pend[w_entry_waddr[i]] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  // A queued result to the same register, or a full queue, holds the pipeline.
  assign w_pipe_ok   = pipe_wr && (pipe_waddr != '0);
  assign pipe_stall  = w_pipe_ok && (w_pend[pipe_waddr] || w_full);
  assign w_load_pipe = w_pipe_ok && !pipe_stall;
  assign w_pop       = !w_empty && (w_full || !w_load_pipe);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (w_pop) begin
      reg_wr <= 1'b1;
      waddr  <= w_head.waddr;
      wdata  <= w_head.wdata;
    end else if (w_load_pipe) begin
      reg_wr <= 1'b1;
      waddr  <= pipe_waddr;
      wdata  <= pipe_wdata;
    end else begin
      reg_wr <= 1'b0;
    end
  end

  assign busy1 = (raddr1 != '0) && (w_pend[raddr1] || (reg_wr && (waddr == raddr1)));
  assign busy2 = (raddr2 != '0) && (w_pend[raddr2] || (reg_wr && (waddr == raddr2)));

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_unit.sv
// ============================================================================
// Module : tb_regfile_writeback_unit
// Directed vectors for the register-file write-back controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback_unit;

  logic        clk;
  logic        reset;
  logic        pipe_wr;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int vectors;
  int miscompares;

  logic [31:0] rf [32];

  regfile_writeback_unit #(
    .XLEN  (32),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_wr    (pipe_wr),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_waddr  (lsu_waddr),
    .lsu_wdata  (lsu_wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .reg_wr     (reg_wr),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shadow of the register file, updated by the write port
  always @(posedge clk) begin
    if (reg_wr) rf[waddr] <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    pipe_wr     = 1'b0;
    pipe_waddr  = '0;
    pipe_wdata  = '0;
    lsu_valid   = 1'b0;
    lsu_waddr   = '0;
    lsu_wdata   = '0;
    raddr1      = 5'd3;
    raddr2      = 5'd0;

    // Reset state
    #2;
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_busy1", busy1, 0);
    next();
    reset = 1'b1;
    #1;
    chk("rel_lsu_ready", lsu_ready, 1);

    // Single pipeline write
    next();
    pipe_wr = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF; raddr1 = 5'd5;
    #1;
    chk("pw_stall", pipe_stall, 0);
    chk("pw_busy_pre", busy1, 0);
    next();
    pipe_wr = 1'b0;
    #1;
    chk("pw_reg_wr", reg_wr, 1);
    chk("pw_waddr", waddr, 5);
    chk("pw_wdata", wdata, 32'hDEADBEEF);
    chk("pw_busy_out", busy1, 1);
    next();
    chk("pw_reg_wr_off", reg_wr, 0);
    chk("pw_busy_off", busy1, 0);

    // WAW: late x7 queued before pipeline x7
    next();
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h11; raddr1 = 5'd7;
    #1;
    chk("waw_ready", lsu_ready, 1);
    next();
    lsu_valid = 1'b0;
    pipe_wr = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h22;
    #1;
    chk("waw_stall", pipe_stall, 1);
    chk("waw_busy", busy1, 1);
    chk("waw_idle", reg_wr, 0);
    next();
    chk("waw_first_wr", reg_wr, 1);
    chk("waw_first_addr", waddr, 7);
    chk("waw_first_data", wdata, 32'h11);
    chk("waw_unstall", pipe_stall, 0);
    next();
    pipe_wr = 1'b0;
    chk("waw_second_wr", reg_wr, 1);
    chk("waw_second_data", wdata, 32'h22);
    next();
    chk("waw_done", reg_wr, 0);
    chk("waw_final_x7", rf[7], 32'h22);

    // Full FIFO with continuous pipeline writes to x9
    for (int k = 0; k < 4; k++) begin
      next();
      lsu_valid = 1'b1; lsu_waddr = 5'(k + 1); lsu_wdata = 32'hA1 + 32'(k);
      pipe_wr = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h90 + 32'(k);
      #1;
      chk("full_fill_ready", lsu_ready, 1);
      chk("full_fill_stall", pipe_stall, 0);
      if (k > 0) chk("full_fill_wdata", wdata, 32'h90 + 32'(k - 1));
    end
    next();
    lsu_waddr = 5'd5; lsu_wdata = 32'hA5; pipe_wdata = 32'h94;
    #1;
    chk("full_ready", lsu_ready, 0);
    chk("full_stall", pipe_stall, 1);
    chk("full_out_data", wdata, 32'h93);
    next();
    lsu_valid = 1'b0;
    chk("full_pop_addr", waddr, 1);
    chk("full_pop_data", wdata, 32'hA1);
    chk("full_pop_unstall", pipe_stall, 0);
    chk("full_pop_ready", lsu_ready, 1);
    next();
    pipe_wdata = 32'h95;
    chk("full_pipe_addr", waddr, 9);
    chk("full_pipe_data", wdata, 32'h94);
    next();
    pipe_wr = 1'b0;
    chk("full_pipe2_data", wdata, 32'h95);
    next();
    chk("full_drain2_addr", waddr, 2);
    chk("full_drain2_data", wdata, 32'hA2);
    next();
    chk("full_drain3_data", wdata, 32'hA3);
    next();
    chk("full_drain4_addr", waddr, 4);
    chk("full_drain4_data", wdata, 32'hA4);
    next();
    chk("full_empty", reg_wr, 0);
    chk("full_x1", rf[1], 32'hA1);
    chk("full_x2", rf[2], 32'hA2);
    chk("full_x3", rf[3], 32'hA3);
    chk("full_x4", rf[4], 32'hA4);
    chk("full_x5_untouched", rf[5], 32'hDEADBEEF);
    chk("full_x9", rf[9], 32'h95);

    // x0 handling
    next();
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h55;
    pipe_wr = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h66; raddr1 = 5'd0;
    #1;
    chk("x0_ready", lsu_ready, 1);
    chk("x0_stall", pipe_stall, 0);
    chk("x0_busy", busy1, 0);
    next();
    lsu_valid = 1'b0; pipe_wr = 1'b0;
    chk("x0_no_pipe_wr", reg_wr, 0);
    next();
    chk("x0_no_lsu_wr", reg_wr, 0);
    chk("x0_ready_after", lsu_ready, 1);

    // Busy tracking on x12
    next();
    lsu_valid = 1'b1; lsu_waddr = 5'd12; lsu_wdata = 32'hC0C00012;
    raddr1 = 5'd12; raddr2 = 5'd12;
    #1;
    chk("busy_pre", busy1, 0);
    next();
    lsu_valid = 1'b0;
    pipe_wr = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h99;
    #1;
    chk("busy_queued1", busy1, 1);
    chk("busy_queued2", busy2, 1);
    chk("busy_indep_stall", pipe_stall, 0);
    next();
    pipe_wr = 1'b0;
    chk("busy_behind_pipe", busy1, 1);
    chk("busy_pipe_addr", waddr, 9);
    next();
    chk("busy_writing", busy1, 1);
    chk("busy_wr_addr", waddr, 12);
    chk("busy_wr_en", reg_wr, 1);
    next();
    chk("busy_clear", busy1, 0);
    chk("busy_clear_wr", reg_wr, 0);

    // Reset mid-stream with three entries queued
    for (int k = 0; k < 3; k++) begin
      next();
      lsu_valid = 1'b1; lsu_waddr = 5'(20 + k); lsu_wdata = 32'hB0 + 32'(k);
      pipe_wr = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h70 + 32'(k);
      #1;
      chk("mid_fill_ready", lsu_ready, 1);
    end
    next();
    lsu_valid = 1'b0; pipe_wr = 1'b0; raddr1 = 5'd20;
    #1;
    chk("mid_busy_queued", busy1, 1);
    chk("mid_out_data", wdata, 32'h72);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_reg_wr", reg_wr, 0);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_ready", lsu_ready, 0);
    chk("mid_rst_busy", busy1, 0);
    next();
    reset = 1'b1;
    #1;
    chk("mid_rel_ready", lsu_ready, 1);
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r);
      #1;
      chk("mid_busy_all", busy1, 0);
    end
    chk("mid_no_write", reg_wr, 0);
    next();
    chk("mid_no_write_next", reg_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
